// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - unified memory port bus with valid/ready handshake
// master drives the request side; slave is the memory returning data and ready.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_valid;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_valid,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ready
  );

  modport slave (
    input  mem_valid,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ready
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for one shared memory port
// Data wins ties unless fetch has lost STARVE_LIMIT grants in a row; hung accesses abort on TIMEOUT.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int TIMEOUT      = 255,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              err,
  output logic              stall,
  mem_port_arbiter_if.master mem
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_BUSY_IF = 2'd1;
  localparam logic [1:0] S_BUSY_DM = 2'd2;
  localparam logic [1:0] S_ACK     = 2'd3;

  localparam int WAIT_W   = $clog2(TIMEOUT + 2);
  localparam int STARVE_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [WAIT_W-1:0]   TIMEOUT_V = WAIT_W'(TIMEOUT);
  localparam logic [STARVE_W-1:0] STARVE_V  = STARVE_W'(STARVE_LIMIT);

  logic [1:0]          state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                mem_valid_q, mem_valid_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                if_ack_q, if_ack_d;
  logic                dm_ack_q, dm_ack_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;

  logic              [WAIT_W-1:0] wait_inc;
  logic              mem_done;
  logic              mem_timeout;
  logic              grant_dm;
  logic [DATA_W-1:0] rdata_capt;

  assign wait_inc    = wait_q + WAIT_W'(1);
  assign mem_done    = mem_valid_q & mem.mem_ready;
  // The counter reaching TIMEOUT on this edge means mem_valid has been up TIMEOUT cycles.
  assign mem_timeout = (TIMEOUT != 0) && mem_valid_q && !mem.mem_ready && (wait_inc == TIMEOUT_V);
  assign grant_dm    = dm_req && !(if_req && (starve_q == STARVE_V));
  assign rdata_capt  = mem_timeout ? '0 : mem.mem_rdata;

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    starve_d    = starve_q;
    mem_valid_d = mem_valid_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    err_d       = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;

    case (state_q)
      S_IDLE: begin
        wait_d = '0;
        if (grant_dm) begin
          state_d     = S_BUSY_DM;
          mem_valid_d = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          if (!if_req) begin
            starve_d = '0;
          end else if (starve_q != STARVE_V) begin
            starve_d = starve_q + STARVE_W'(1);
          end
        end else if (if_req) begin
          state_d     = S_BUSY_IF;
          mem_valid_d = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          starve_d    = '0;
        end
      end
      S_BUSY_IF, S_BUSY_DM: begin
        if (mem_done || mem_timeout) begin
          state_d     = S_ACK;
          mem_valid_d = 1'b0;
          err_d       = mem_timeout;
          if (state_q == S_BUSY_IF) begin
            if_ack_d   = 1'b1;
            if_rdata_d = rdata_capt;
          end else begin
            dm_ack_d = 1'b1;
            if (!mem_we_q) begin
              dm_rdata_d = rdata_capt;
            end
          end
        end else begin
          wait_d = wait_inc;
        end
      end
      default: begin
        state_d = S_IDLE;
        wait_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      wait_q      <= '0;
      starve_q    <= '0;
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      err_q       <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      starve_q    <= starve_d;
      mem_valid_q <= mem_valid_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      err_q       <= err_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  assign mem.mem_valid = mem_valid_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign if_ack        = if_ack_q;
  assign dm_ack        = dm_ack_q;
  assign err           = err_q;
  assign if_rdata      = if_rdata_q;
  assign dm_rdata      = dm_rdata_q;
  assign stall         = (if_req & ~if_ack_q) | (dm_req & ~dm_ack_q);

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one external unified memory port between instruction fetch (read-only) and the MEM stage data access (read/write).
- Sits between the pipeline stages and the memory. Serialises accesses with a variable-latency valid/ready handshake.
- Produces a global pipeline stall while any request is outstanding.
- Gives data accesses priority, with a starvation guard for fetch, and aborts hung accesses on a timeout.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 255, maximum number of cycles to wait for mem_ready per access; 0 disables the timeout.
- STARVE_LIMIT, 4, maximum consecutive DM grants while IF is waiting before IF is forced to win.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- if_req  in  1  fetch request; held with if_addr stable until if_ack.
- if_addr  in  ADDR_W  fetch address.
- if_ack  out  1  one-cycle completion pulse for fetch.
- if_rdata  out  DATA_W  fetched word; valid in the if_ack cycle and held until the next IF completion.
- dm_req  in  1  data request; held with dm_we, dm_addr and dm_wdata stable until dm_ack.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  store data.
- dm_ack  out  1  one-cycle completion pulse for data.
- dm_rdata  out  DATA_W  load data; updated only on load completion, otherwise held.
- err  out  1  high together with the ack of an access aborted by timeout.
- stall  out  1  (if_req & ~if_ack) | (dm_req & ~dm_ack); combinational from inputs and registered acks.
- mem_valid  out  1  external request valid.
- mem_we  out  1  external write enable.
- mem_addr  out  ADDR_W  external address.
- mem_wdata  out  DATA_W  external write data.
- mem_rdata  in  DATA_W  external read data; valid when mem_ready=1.
- mem_ready  in  1  external completion; a transfer occurs when mem_valid & mem_ready.

Behaviour:
- Reset (rst=0 at an edge):
  - State goes to IDLE; wait counter and starve counter cleared.
  - All registered outputs go to 0: mem_valid, mem_we, mem_addr, mem_wdata, if_ack, dm_ack, if_rdata, dm_rdata, err.
  - Reset mid-access abandons the access: mem_valid is 0 after the edge and no ack is ever issued for it.
- FSM states: IDLE, BUSY_IF, BUSY_DM, ACK.
- IDLE:
  - No request: stay in IDLE.
  - Only one request: grant it.
  - Both requested: grant DM, unless starve counter == STARVE_LIMIT, in which case grant IF.
  - On grant: register address/data into mem_*, set mem_valid=1, go to BUSY_IF or BUSY_DM.
  - IF grant drives mem_we=0 and mem_wdata=0.
- BUSY_x:
  - mem_valid, mem_we, mem_addr and mem_wdata held stable.
  - Wait counter increments each cycle mem_ready=0.
  - On mem_valid & mem_ready: mem_valid goes to 0 next cycle, capture mem_rdata (IF, or DM load only), go to ACK, raise the matching ack for one cycle with err=0.
  - Timeout: when TIMEOUT != 0 and the wait counter reaches TIMEOUT with mem_ready still 0, drop mem_valid, go to ACK, raise ack with err=1, and set the corresponding rdata to 0 (for loads and fetches).
- ACK:
  - Ack and err high for exactly one cycle; requests are ignored in this cycle.
  - Next state is IDLE; wait counter cleared.
  - A req still high in the following IDLE cycle is treated as a new request.
- Latency: req first seen in IDLE at cycle 0 -> mem_valid at cycle 1 -> earliest mem_ready at cycle 1 -> ack at cycle 2 -> IDLE at cycle 3. Minimum of 3 cycles per access.
- Starve counter:
  - +1 on a DM grant while if_req=1, saturating at STARVE_LIMIT.
  - Cleared on any IF grant, and on a DM grant while if_req=0.
- Request withdrawal: a req dropping while its access is BUSY does not abort it; the access completes and the ack still pulses.
- mem_ready while mem_valid=0 is ignored.
- Address and data are passed through unmodified; no alignment checks are made.

Test Plan:
- Single fetch: if_req=1, if_addr=0x0000_0040; mem_ready asserted 2 cycles after mem_valid with mem_rdata=0x2002_0005 -> mem_addr=0x40, mem_we=0; one-cycle if_ack with if_rdata=0x2002_0005; stall high until the ack cycle.
- Store priority: if_req and dm_req both high in the same IDLE cycle, dm_we=1, dm_addr=0x100, dm_wdata=0xDEAD_BEEF -> DM served first (mem_we=1, mem_wdata=0xDEADBEEF); IF served on the next IDLE; dm_rdata unchanged.
- Starvation guard: dm_req and if_req held continuously with STARVE_LIMIT=4, mem_ready always 1 -> grant order DM,DM,DM,DM,IF,DM,…
- Timeout: TIMEOUT=8, dm load, mem_ready stuck at 0 -> mem_valid high 8 cycles, then dm_ack=1, err=1, dm_rdata=0; the next access completes normally with err=0.
- Reset mid-access: rst=0 while in BUSY_IF -> all outputs 0 next cycle, no if_ack; after release a pending if_req is regranted from IDLE.
- Back-to-back loads with mem_ready tied to 1 -> an ack every 3 cycles; mem_valid never high in the ACK cycle.
